// File: rtl/eth_rx_port_arbiter.sv
// ============================================================================
//  Module      : eth_rx_port_arbiter
//  Description : Frame-granular round-robin arbiter sharing one AXI-Stream
//                parser ingress between NUM_PORTS MAC receive ports. The
//                grant is locked for a whole frame, each beat is tagged with
//                its source port, and frames longer than MAX_FRAME_BEATS are
//                cut short with a forced tlast while the rest is drained.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_rx_port_arbiter #(
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_PORTS       = 4,
   parameter int MAX_FRAME_BEATS = 2048,
   parameter int PORT_W          = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [PORT_W-1:0]               m_axis_tid,
   output logic                            frame_start,
   output logic                            trunc_event
);

   localparam int                CNT_W    = $clog2(MAX_FRAME_BEATS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_FRAME_BEATS - 1);
   localparam logic [PORT_W-1:0] PORT_TOP = PORT_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FWD   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                 state_q;
   logic [PORT_W-1:0]      grant_q;
   logic [PORT_W-1:0]      last_grant_q;
   logic [CNT_W-1:0]       beat_cnt_q;
   logic                   trunc_q;

   logic [DATA_WIDTH-1:0]  w_port_data [NUM_PORTS];
   logic [PORT_W-1:0]      w_pick;
   logic                   w_pick_vld;
   logic [PORT_W-1:0]      w_idx;
   logic                   w_in_vld;
   logic                   w_in_last;
   logic                   w_at_limit;
   logic                   w_fwd_hs;

   // Split the flat ingress data bus into one word per port
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_split
         assign w_port_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign w_in_vld   = s_axis_tvalid[grant_q];
   assign w_in_last  = s_axis_tlast[grant_q];
   assign w_at_limit = (beat_cnt_q == CNT_LAST);
   assign w_fwd_hs   = (state_q == ST_FWD) && w_in_vld && m_axis_tready;

   // Round-robin pick: first requester after last_grant; scanning from the far
   // end lets the nearest requester overwrite the others.
   always_comb begin
      w_pick     = '0;
      w_pick_vld = 1'b0;
      w_idx      = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_idx = PORT_W'((int'(last_grant_q) + k) % NUM_PORTS);
         if (s_axis_tvalid[w_idx]) begin
            w_pick     = w_idx;
            w_pick_vld = 1'b1;
         end
      end
   end

   // Zero-latency datapath mux and per-port ready steering
   always_comb begin
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tid    = '0;
      frame_start   = 1'b0;
      case (state_q)
         ST_FWD: begin
            m_axis_tvalid          = w_in_vld;
            m_axis_tdata           = w_port_data[grant_q];
            m_axis_tid             = grant_q;
            m_axis_tlast           = w_in_last | w_at_limit;
            s_axis_tready[grant_q] = m_axis_tready;
            frame_start            = w_fwd_hs && (beat_cnt_q == '0);
         end
         ST_DRAIN: begin
            s_axis_tready[grant_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign trunc_event = trunc_q;

   // Frame FSM: arbitrate in IDLE, forward until tlast or length limit, drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= PORT_TOP;
         beat_cnt_q   <= '0;
         trunc_q      <= 1'b0;
      end else begin
         trunc_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               beat_cnt_q <= '0;
               if (w_pick_vld) begin
                  grant_q <= w_pick;
                  state_q <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (w_fwd_hs) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (w_in_last) begin
                     // A real tlast always wins, even on the limit beat
                     state_q      <= ST_IDLE;
                     last_grant_q <= grant_q;
                     beat_cnt_q   <= '0;
                  end else if (w_at_limit) begin
                     state_q <= ST_DRAIN;
                     trunc_q <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_in_vld && w_in_last) begin
                  state_q      <= ST_IDLE;
                  last_grant_q <= grant_q;
                  beat_cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_port_arbiter.sv
// ============================================================================
//  Module      : tb_eth_rx_port_arbiter
//  Description : Self-checking bench for eth_rx_port_arbiter. Per-port frame
//                queues feed the DUT; a frame-level round-robin model derives
//                the expected output beat stream and truncation count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_rx_port_arbiter;

   localparam int NP   = 4;
   localparam int DW   = 8;
   localparam int MAXB = 4;
   localparam int QD   = 64;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NP*DW-1:0] s_tdata = '0;
   logic [NP-1:0]  s_tvalid = '0;
   logic [NP-1:0]  s_tready;
   logic [NP-1:0]  s_tlast = '0;
   logic [DW-1:0]  m_tdata;
   logic           m_tvalid;
   logic           m_tready = 1'b0;
   logic           m_tlast;
   logic [1:0]     m_tid;
   logic           frame_start;
   logic           trunc_event;

   int vectors = 0;
   int miscompares = 0;

   // per-port beat storage: bit 8 = tlast, bits 7:0 = data
   logic [8:0] pmem [NP][QD];
   int         phead [NP];
   int         ptail [NP];

   // expected beats: {frame_start, tid[1:0], tlast, data[7:0]}
   logic [11:0] exp_q [$];
   int          exp_trunc;

   int  rmode;
   bit  rpat [16];
   int  rlen;
   int  ridx;

   eth_rx_port_arbiter #(
      .DATA_WIDTH      (DW),
      .NUM_PORTS       (NP),
      .MAX_FRAME_BEATS (MAXB)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .frame_start   (frame_start),
      .trunc_event   (trunc_event)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add_frame(input int p, input int len, input bit rnd, input logic [7:0] d0);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom_range(0, 255)) : 8'(d0 + 8'(i * 17));
         pmem[p][ptail[p]] = {(i == len - 1), d};
         ptail[p]++;
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (phead[p] < ptail[p]) begin
            s_tvalid[p]         = 1'b1;
            s_tdata[p*DW +: DW] = pmem[p][phead[p]][7:0];
            s_tlast[p]          = pmem[p][phead[p]][8];
         end else begin
            s_tvalid[p]         = 1'b0;
            s_tdata[p*DW +: DW] = '0;
            s_tlast[p]          = 1'b0;
         end
      end
   endtask

   task automatic set_ready();
      if (rmode == 0)      m_tready = 1'b1;
      else if (rmode == 1) m_tready = ($urandom_range(0, 3) != 0);
      else begin
         m_tready = (ridx < rlen) ? rpat[ridx] : 1'b1;
         ridx++;
      end
   endtask

   // Frame-level round robin over ports holding pending frames, starting
   // after port NP-1 as if freshly reset.
   function automatic void build_model();
      int h [NP];
      int lastp;
      int p;
      int n;
      bit found;
      logic [8:0] b;
      exp_q.delete();
      exp_trunc = 0;
      for (int i = 0; i < NP; i++) h[i] = phead[i];
      lastp = NP - 1;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= NP; k++) begin
            p = (lastp + k) % NP;
            if (!found && h[p] < ptail[p]) begin
               found = 1'b1;
               n = 0;
               do begin
                  b = pmem[p][h[p]];
                  h[p]++;
                  n++;
                  if (n <= MAXB)
                     exp_q.push_back({(n == 1), 2'(p), (b[8] || n == MAXB), b[7:0]});
                  if (n == MAXB && !b[8]) exp_trunc++;
               end while (!b[8]);
               lastp = p;
            end
         end
      end
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_s_tready"}, s_tready, 0);
      chk({tag, "_m_tvalid"}, m_tvalid, 0);
      chk({tag, "_m_tlast"}, m_tlast, 0);
      chk({tag, "_m_tdata"}, m_tdata, 0);
      chk({tag, "_m_tid"}, m_tid, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_trunc_event"}, trunc_event, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int p = 0; p < NP; p++) begin
         phead[p] = 0;
         ptail[p] = 0;
      end
      drive();
      m_tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int stop_hs, input int budget, output int hs_cnt, output int first_hs);
      int          cyc;
      bit          done;
      bit          stall_prev;
      logic [11:0] prev_obs;
      logic [11:0] obs;
      int          trunc_seen;
      logic [NP-1:0] hs;
      cyc = 0; hs_cnt = 0; first_hs = 0; stall_prev = 1'b0;
      prev_obs = '0; trunc_seen = 0; done = 1'b0;
      set_ready();
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         obs = {frame_start, m_tid, m_tlast, m_tdata};
         chk("ready_onehot", ($countones(s_tready) <= 1), 1);
         if (m_tvalid) begin
            chk("ready_mirror", s_tready[m_tid], m_tready);
            chk("other_ready", s_tready & ~(4'b0001 << m_tid), 0);
         end
         if (stall_prev)
            chk("stall_hold", {m_tvalid, obs[10:0]}, {1'b1, prev_obs[10:0]});
         if (trunc_event) trunc_seen++;
         if (m_tvalid && m_tready) begin
            hs_cnt++;
            if (first_hs == 0) first_hs = cyc;
            chk("beat_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("beat", obs, exp_q.pop_front());
         end else begin
            chk("no_frame_start", frame_start, 0);
         end
         stall_prev = m_tvalid && !m_tready;
         prev_obs   = obs;
         hs         = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) if (hs[p]) phead[p]++;
         drive();
         set_ready();
         if (stop_hs > 0 && hs_cnt >= stop_hs) return;
         done = (exp_q.size() == 0);
         for (int p = 0; p < NP; p++) if (phead[p] < ptail[p]) done = 1'b0;
      end
      chk("run_done", done, 1);
      chk("trunc_count", trunc_seen, exp_trunc);
      repeat (2) begin
         @(negedge clk);
         chk("idle_valid", m_tvalid, 0);
         chk("idle_ready", s_tready, 0);
      end
   endtask

   initial begin
      int hs;
      int fh;
      for (int p = 0; p < NP; p++) begin
         phead[p] = 0;
         ptail[p] = 0;
      end
      rmode = 0; rlen = 0; ridx = 0;

      // single port 2, 3-beat frame, one arbitration bubble
      do_reset();
      add_frame(2, 3, 1'b0, 8'h11);
      drive();
      build_model();
      rmode = 0;
      run(0, 200, hs, fh);
      chk("p2_first_hs_cycle", fh, 2);
      chk("p2_handshakes", hs, 3);

      // ports 0,1,3 together, port 0 with a second frame
      do_reset();
      add_frame(0, 2, 1'b0, 8'hA0);
      add_frame(1, 2, 1'b0, 8'hB0);
      add_frame(3, 2, 1'b0, 8'hD0);
      add_frame(0, 2, 1'b0, 8'hC0);
      drive();
      build_model();
      run(0, 200, hs, fh);
      chk("rr_handshakes", hs, 8);

      // backpressure 1,0,0,1 during a 4-beat frame on port 1
      do_reset();
      add_frame(1, 4, 1'b1, 8'h00);
      drive();
      build_model();
      rmode = 2; ridx = 0; rlen = 5;
      rpat[0] = 1'b1; rpat[1] = 1'b1; rpat[2] = 1'b0; rpat[3] = 1'b0; rpat[4] = 1'b1;
      run(0, 200, hs, fh);
      chk("bp_handshakes", hs, 4);

      // 6-beat frame truncated to 4, remainder drained
      do_reset();
      add_frame(0, 6, 1'b1, 8'h00);
      drive();
      build_model();
      rmode = 0;
      run(0, 200, hs, fh);
      chk("trunc_expected", exp_trunc, 1);
      chk("trunc_handshakes", hs, 4);

      // exactly MAX beats, tlast on the limit beat
      do_reset();
      add_frame(0, 4, 1'b1, 8'h00);
      drive();
      build_model();
      run(0, 200, hs, fh);
      chk("exact_handshakes", hs, 4);

      // asynchronous reset in the middle of a port 2 frame
      do_reset();
      add_frame(2, 5, 1'b1, 8'h00);
      drive();
      build_model();
      run(2, 200, hs, fh);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      add_frame(0, 2, 1'b1, 8'h00);
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      build_model();
      chk("after_rst_first_port", exp_q[0][10:9], 0);
      run(0, 200, hs, fh);

      // randomized frames, lengths and backpressure
      for (int r = 0; r < 20; r++) begin
         do_reset();
         for (int p = 0; p < NP; p++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 6), 1'b1, 8'h00);
         end
         drive();
         build_model();
         rmode = 1;
         run(0, 3000, hs, fh);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/eth_rx_port_arbiter.md
Name: eth_rx_port_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single `ethernet_frame_parser` AXI-Stream ingress between NUM_PORTS MAC receive ports.
- Locks the grant from the first beat of a frame until its tlast, then rotates to the next port.
- Tags each output beat with its source port.
- Enforces a maximum frame length: oversize frames are truncated (forced tlast) and the remainder is drained.
- Sits directly in front of the parser's s_axis interface.

Parameters:
- DATA_WIDTH, 8, beat width in bits; matches the parser.
- NUM_PORTS, 4, number of ingress ports, >= 2.
- MAX_FRAME_BEATS, 2048, maximum beats forwarded per frame, >= 2.
- PORT_W, $clog2(NUM_PORTS), width of the port id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port i data at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- m_axis_tdata  out  DATA_WIDTH  to parser.
- m_axis_tvalid  out  1  to parser.
- m_axis_tready  in  1  from parser.
- m_axis_tlast  out  1  to parser; includes the forced truncation last.
- m_axis_tid  out  PORT_W  source port of the current beat.
- frame_start  out  1  one-cycle pulse on the first output handshake of a frame.
- trunc_event  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Clocking and reset: single clock domain, rising edge. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 has first priority), beat_cnt=0.
  - All outputs 0: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, frame_start=0, trunc_event=0.
- Datapath: combinational mux from the granted port to m_axis; zero-cycle latency in FWD.
- beat_cnt: width $clog2(MAX_FRAME_BEATS+1); counts handshakes of the current frame; cleared on entry to IDLE.
- IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - If any s_axis_tvalid is set, pick the first asserted port scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Register that port into grant and go to FWD next cycle. This costs a one-cycle arbitration bubble per frame.
  - If no valid is asserted, stay in IDLE.
- FWD:
  - m_axis_tvalid=s_axis_tvalid[grant], m_axis_tdata=port grant data, m_axis_tid=grant.
  - s_axis_tready[grant]=m_axis_tready; all other readies are 0.
  - m_axis_tlast=s_axis_tlast[grant], OR forced to 1 when beat_cnt==MAX_FRAME_BEATS-1.
  - On a handshake: beat_cnt++. frame_start=1 if beat_cnt was 0.
  - Handshake with s_axis_tlast=1: go to IDLE, last_grant<=grant, no truncation. This holds even when it lands exactly on beat MAX_FRAME_BEATS.
  - Handshake with beat_cnt==MAX_FRAME_BEATS-1 and s_axis_tlast=0: trunc_event pulses on the next cycle; go to DRAIN.
  - If valid drops mid-frame, the grant is held; no timeout.
- DRAIN:
  - s_axis_tready[grant]=1, m_axis_tvalid=0; input beats are discarded.
  - On a tlast handshake: go to IDLE, last_grant<=grant.
- Outputs are stable while m_axis_tvalid=1 and m_axis_tready=0, because they mirror the held granted input, which must obey AXI stability.
- A single-beat frame (tlast on the first beat) completes FWD in one handshake. frame_start and IDLE transition happen on the same edge.
- Simultaneous events: a new request arriving on the port being released in the same cycle is served only after the other requesting ports (round-robin fairness).
- Reset mid-frame: immediate return to IDLE. The partial frame downstream is not terminated; the parser must tolerate this after reset.

Test Plan:
- Single port 2, 3-beat frame 0x11,0x22,0x33 (last on 0x33), m_tready=1 -> one bubble cycle, then 3 output beats with m_axis_tid=2; frame_start on beat 0x11; tlast on 0x33; other readies 0 throughout.
- Ports 0,1,3 each hold a 2-beat frame asserted simultaneously after reset -> output order 0,1,3, no interleaving; then a new frame on port 0 is served after 3.
- Downstream backpressure: m_tready toggles 1,0,0,1 during a 4-beat frame on port 1 -> data, tid and tlast stable while stalled; exactly 4 handshakes; s_tready[1] mirrors m_tready.
- MAX_FRAME_BEATS=4, port 0 sends a 6-beat frame -> 4 beats out with forced tlast on beat 4; trunc_event pulses once; beats 5-6 consumed with m_tvalid=0; then IDLE.
- MAX_FRAME_BEATS=4, exactly 4-beat frame -> no trunc_event; normal completion.
- rst_n asserted mid-frame on port 2 (beat 2 of 5) -> all outputs 0 asynchronously; after release, port 0 wins if it requests together with port 2.
